// File: rtl/signdet_score_argmax.sv
// ---------------------------------------------------------------------------
// signdet_score_argmax : per-frame argmax and best/second-best margin of scores
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module signdet_score_argmax #(
  parameter int NUM_CLASS = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic        i_we,
  input  logic [15:0] i_score,
  output logic [4:0]  o_max_idx,
  output logic [15:0] o_diff,
  output logic        o_validp,
  output logic        o_busy,
  output logic        o_err
);

  localparam logic [4:0] C_LAST_K = 5'(NUM_CLASS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [4:0]         r_k, w_k_eff, w_k_nxt;
  logic [4:0]         r_idx, w_idx_nxt;
  logic signed [15:0] r_best, r_second, w_best_nxt, w_second_nxt;
  logic signed [15:0] w_score;
  logic               w_accept, w_last, w_err;
  logic [15:0]        w_diff;

  assign w_score = $signed(i_score);

  always_comb begin
    w_state_nxt  = r_state;
    w_best_nxt   = r_best;
    w_second_nxt = r_second;
    w_idx_nxt    = r_idx;
    // A start in the same cycle as a write makes that write class 0.
    w_k_eff      = i_start ? 5'd0 : r_k;
    w_k_nxt      = w_k_eff;
    w_accept     = i_we && (i_start || (r_state == ACC));
    w_last       = w_accept && (w_k_eff == C_LAST_K);
    w_err        = (i_start && (r_state == ACC)) ||
                   (i_we && (r_state == IDLE) && !i_start);

    if (w_accept) begin
      w_k_nxt = w_k_eff + 5'd1;
      if (w_k_eff == 5'd0) begin
        w_best_nxt   = w_score;
        w_second_nxt = 16'sh8000;
        w_idx_nxt    = 5'd0;
      end else if (w_score > r_best) begin
        w_second_nxt = r_best;
        w_best_nxt   = w_score;
        w_idx_nxt    = w_k_eff;
      end else if (w_score > r_second) begin
        w_second_nxt = w_score;
      end
    end

    if (w_last) begin
      w_state_nxt = IDLE;
      w_k_nxt     = 5'd0;
    end else if (i_start) begin
      w_state_nxt = ACC;
    end
  end

  // best >= second always, so the true difference is 0..65535 and the low
  // 16 bits of the wrapped subtraction are exact.
  assign w_diff = 16'(w_best_nxt - w_second_nxt);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_k       <= 5'd0;
      r_idx     <= 5'd0;
      r_best    <= 16'sh8000;
      r_second  <= 16'sh8000;
      o_max_idx <= C_LAST_K;
      o_diff    <= 16'd0;
      o_validp  <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_k      <= w_k_nxt;
      r_idx    <= w_idx_nxt;
      r_best   <= w_best_nxt;
      r_second <= w_second_nxt;
      o_validp <= w_last;
      o_err    <= w_err;
      if (w_last) begin
        o_max_idx <= w_idx_nxt;
        o_diff    <= w_diff;
      end
    end
  end

  assign o_busy = (r_state == ACC);

endmodule

`default_nettype wire

// File: tb/tb_signdet_score_argmax.sv
// ---------------------------------------------------------------------------
// tb_signdet_score_argmax : randomized bench against a frame-level argmax model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_signdet_score_argmax;

  localparam int NUM_CLASS = 10;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_start, i_we;
  logic [15:0] i_score;
  logic [4:0]  o_max_idx;
  logic [15:0] o_diff;
  logic        o_validp, o_busy, o_err;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  bit          m_active;
  logic [15:0] m_q[$];
  logic [4:0]  m_idx;
  logic [15:0] m_diff;
  bit          m_validp, m_err;

  logic [15:0] fs[NUM_CLASS];

  always #5 clk = ~clk;

  signdet_score_argmax #(.NUM_CLASS(NUM_CLASS)) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .i_start   (i_start),
    .i_we      (i_we),
    .i_score   (i_score),
    .o_max_idx (o_max_idx),
    .o_diff    (o_diff),
    .o_validp  (o_validp),
    .o_busy    (o_busy),
    .o_err     (o_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Argmax over a complete frame: first index of the maximum wins, margin is
  // the maximum minus the largest of the remaining entries.
  task automatic model_finish();
    int best, second, bi, v;
    best = -70000;
    bi = 0;
    for (int i = 0; i < NUM_CLASS; i++) begin
      v = int'($signed(m_q[i]));
      if (v > best) begin best = v; bi = i; end
    end
    second = -32768;
    for (int i = 0; i < NUM_CLASS; i++) begin
      v = int'($signed(m_q[i]));
      if (i != bi && v > second) second = v;
    end
    m_idx  = 5'(bi);
    m_diff = 16'(best - second);
  endtask

  task automatic model_reset();
    m_active = 0;
    m_q.delete();
    m_idx    = 5'(NUM_CLASS - 1);
    m_diff   = 16'd0;
    m_validp = 0;
    m_err    = 0;
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_validp"}, 32'(o_validp), 32'(m_validp));
    check({tag, "_err"},    32'(o_err),    32'(m_err));
    check({tag, "_busy"},   32'(o_busy),   32'(m_active));
    check({tag, "_idx"},    32'(o_max_idx), 32'(m_idx));
    check({tag, "_diff"},   32'(o_diff),   32'(m_diff));
  endtask

  // One clock cycle: drive, clock, update model, compare.
  task automatic step(input bit st, input bit we, input logic [15:0] sc, input string tag);
    i_start = st;
    i_we    = we;
    i_score = sc;
    @(posedge clk);
    #1;
    m_validp = 0;
    m_err    = (st && m_active) || (we && !m_active && !st);
    if (st) begin
      m_active = 1;
      m_q.delete();
    end
    if (we && m_active) begin
      m_q.push_back(sc);
      if (m_q.size() == NUM_CLASS) begin
        model_finish();
        m_validp = 1;
        m_active = 0;
      end
    end
    i_start = 0;
    i_we    = 0;
    check_outs(tag);
  endtask

  task automatic run_frame(input bit start_with_write, input int maxgap, input string tag);
    if (!start_with_write) step(1, 0, 16'h0, tag);
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (!(i == 0 && start_with_write)) begin
        int g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        for (int j = 0; j < g; j++) step(0, 0, 16'h0, tag);
      end
      step((i == 0) && start_with_write, 1, fs[i], tag);
    end
  endtask

  task automatic fill(input logic [15:0] base);
    for (int i = 0; i < NUM_CLASS; i++) fs[i] = base;
  endtask

  task automatic fill_random();
    int mode = int'($urandom_range(0, 2));
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (mode == 0)      fs[i] = 16'($urandom);
      else if (mode == 1) fs[i] = 16'($urandom_range(0, 3));
      else                fs[i] = 16'h8000 + 16'($urandom_range(0, 1)) * 16'h7FFF;
    end
  endtask

  initial begin
    resetn  = 1'b0;
    i_start = 0;
    i_we    = 0;
    i_score = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    @(negedge clk);
    resetn = 1'b1;

    // margin case
    fill(16'h1000); fs[3] = 16'h3000; fs[7] = 16'h2000;
    run_frame(0, 0, "tp_basic");
    check("tp_basic_idx_const", 32'(o_max_idx), 32'd3);
    check("tp_basic_diff_const", 32'(o_diff), 32'h1000);
    step(0, 0, 16'h0, "tp_basic_post");

    // tie: lowest index wins with zero margin
    fill(16'h0100); fs[2] = 16'h0500; fs[5] = 16'h0500;
    run_frame(0, 0, "tp_tie");
    check("tp_tie_idx_const", 32'(o_max_idx), 32'd2);
    check("tp_tie_diff_const", 32'(o_diff), 32'h0);

    // extremes
    fill(16'h8000); fs[0] = 16'h7FFF;
    run_frame(0, 0, "tp_ext");
    check("tp_ext_idx_const", 32'(o_max_idx), 32'd0);
    check("tp_ext_diff_const", 32'(o_diff), 32'hFFFF);

    // negative scores
    fill(16'h8000); fs[9] = 16'hFFFF; fs[0] = 16'hFFFE;
    run_frame(0, 0, "tp_neg");
    check("tp_neg_idx_const", 32'(o_max_idx), 32'd9);
    check("tp_neg_diff_const", 32'(o_diff), 32'h0001);

    // abort after 4 writes, then a full frame
    step(1, 0, 16'h0, "tp_abort");
    for (int i = 0; i < 4; i++) step(0, 1, 16'h7000, "tp_abort");
    fill(16'h0200); fs[6] = 16'h0240;
    run_frame(0, 0, "tp_abort_full");
    check("tp_abort_idx_const", 32'(o_max_idx), 32'd6);
    check("tp_abort_diff_const", 32'(o_diff), 32'h0040);

    // back-to-back: next start lands in the validp cycle
    fill(16'h0010); fs[1] = 16'h0030;
    run_frame(1, 0, "tp_b2b");
    check("tp_b2b_idx_const", 32'(o_max_idx), 32'd1);
    check("tp_b2b_diff_const", 32'(o_diff), 32'h0020);

    // write in IDLE
    step(0, 0, 16'h0, "tp_idle");
    step(0, 1, 16'h1234, "tp_idle_we");
    step(0, 0, 16'h0, "tp_idle_after");

    // gapped frame equals contiguous result
    fill(16'h1000); fs[3] = 16'h3000; fs[7] = 16'h2000;
    run_frame(0, 5, "tp_gap");
    check("tp_gap_idx_const", 32'(o_max_idx), 32'd3);
    check("tp_gap_diff_const", 32'(o_diff), 32'h1000);

    // asynchronous reset mid-frame
    fill_random();
    step(1, 0, 16'h0, "tp_rst");
    for (int i = 0; i < 5; i++) step(0, 1, fs[i], "tp_rst");
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_outs("tp_rst_async");
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 5; i < NUM_CLASS; i++) step(0, 1, fs[i], "tp_rst_tail");

    // randomized frames with gaps, aborts, stray writes and chained starts
    for (int f = 0; f < 60; f++) begin
      int act = int'($urandom_range(0, 7));
      fill_random();
      if (act == 0) begin
        step(1, 0, 16'h0, "rnd_abort");
        for (int i = 0; i < int'($urandom_range(0, NUM_CLASS - 1)); i++)
          step(0, int'($urandom_range(0, 1)) == 1, 16'($urandom), "rnd_abort");
      end else if (act == 1) begin
        step(0, 1, 16'($urandom), "rnd_stray");
      end
      run_frame(act >= 5, int'($urandom_range(0, 3)), "rnd");
    end
    step(0, 0, 16'h0, "final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/signdet_score_argmax.md
Name: signdet_score_argmax

Overview:
Frame-level argmax producer that feeds the gesture decision filter. It accepts the classifier's per-class output scores, one score per write, for NUM_CLASS classes. After the last score of a frame it emits the winning class index and the margin between the best and second-best score, with a one-cycle valid pulse. This is the source of the decision filter's max-index, diff and valid-pulse inputs.

Parameters:
NUM_CLASS, 10, scores per frame. Legal range 2..32. The last class (index NUM_CLASS-1) is the "no gesture" class.

Ports:
clk        input   1   system clock
resetn     input   1   asynchronous active-low reset
i_start    input   1   frame start pulse; (re)arms accumulation
i_we       input   1   score write strobe; may be non-contiguous
i_score    input   16  signed two's-complement class score; class = write order
o_max_idx  output  5   index of the highest score
o_diff     output  16  unsigned (best - second best)
o_validp   output  1   one-cycle pulse: o_max_idx/o_diff updated
o_busy     output  1   high while a frame is being accumulated
o_err      output  1   one-cycle protocol error pulse

Behaviour:
- Reset (async assert, sync release): o_max_idx = NUM_CLASS-1, o_diff = 0, o_validp = 0, o_busy = 0, o_err = 0, state IDLE, class counter = 0.
- States:
  - IDLE: no frame active.
  - ACC: frame active; counter k = number of scores accepted so far.
- i_start in IDLE: go to ACC, k = 0.
- i_start in ACC: abort the current frame, restart at k = 0, pulse o_err next cycle; no o_validp for the aborted frame.
- i_start and i_we in the same cycle: the score is class 0 of the new frame.
- i_we in IDLE without i_start: score discarded, o_err pulses next cycle, no other effect.
- Score accept at k = 0: best = score, idx = 0, second = 16'h8000.
- Score accept at k > 0, using signed compare:
  - score > best (strict): second <= best, best <= score, idx <= k.
  - else if score > second: second <= score.
  - The lowest index wins ties. An equal top score becomes second, giving diff = 0.
- On the NUM_CLASS-th accept (k = NUM_CLASS-1) in cycle t, return to IDLE in cycle t+1 with:
  - o_validp = 1 for exactly that cycle;
  - o_max_idx = final idx;
  - o_diff = best - second, computed in 17 bits signed; the result lies in 0..65535 and is output as [15:0].
- Final values include the score written in cycle t. Latency is 1 cycle from the last write to o_validp.
- o_max_idx and o_diff hold between pulses. They are not changed by aborted frames or by errors.
- o_busy = 1 exactly while in ACC, including the cycle of the last write.
- i_start coinciding with the o_validp cycle is legal and starts the next frame with no lost score.
- Writes beyond NUM_CLASS cannot occur: the block is in IDLE by then, so they are error-ignored.
- i_we gaps of any length inside a frame have no effect on the result.
- resetn asserted mid-frame: frame discarded, all outputs to reset values immediately, no o_validp.

Test Plan:
- Start, then 10 contiguous writes: all 0x1000 except class 3 = 0x3000 and class 7 = 0x2000 → one cycle after the 10th write, o_validp = 1 for one cycle, o_max_idx = 3, o_diff = 0x1000, o_busy falls.
- Tie: classes 2 and 5 = 0x0500, rest 0x0100 → o_max_idx = 2, o_diff = 0. Extreme: class 0 = 0x7FFF, rest 0x8000 → o_max_idx = 0, o_diff = 0xFFFF.
- Negative scores: class 9 = 0xFFFF (-1), class 0 = 0xFFFE, rest 0x8000 → o_max_idx = 9, o_diff = 0x0001.
- Abort: start, 4 writes, i_start again (o_err pulse, no o_validp), then a full frame with class 6 max by 0x0040 → single o_validp, idx = 6, diff = 0x0040. Back-to-back frames with i_start in the o_validp cycle → two pulses with correct results.
- Protocol and gaps:
  - i_we in IDLE → o_err pulse, outputs unchanged, no o_validp.
  - A frame with 0-5 idle cycles between writes → identical result to the contiguous frame.
- Reset: assert resetn low after 5 writes → immediately o_max_idx = 9, o_diff = 0, o_busy = 0. Remaining writes after release → o_err each, no o_validp.
